// File: rtl/id_ex_shift_reg.sv
// ID/EX pipeline register for the shift unit: a two-entry (main + skid) FIFO
// that captures forwarded operands at accept time and presents the head entry.
module id_ex_shift_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  shamt_in,
    input  logic        alusrc_in,
    input  logic [1:0]  type_in,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [4:0]  shamt_out,
    output logic        alusrc_out,
    output logic [1:0]  type_out,
    output logic [4:0]  rd_out,
    output logic        regwrite_out
);

    // Bit 0 = head valid, bit 1 = skid valid, so both handshake outputs are plain flop bits.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    // Entry layout: {a[77:46], b[45:14], shamt[13:9], alusrc[8], type[7:6], rd[5:1], regwrite[0]}
    localparam int ENTRY_W = 78;

    logic [1:0]         state_r, state_s;
    logic [ENTRY_W-1:0] head_r, head_s;
    logic [ENTRY_W-1:0] skid_r, skid_s;
    logic [ENTRY_W-1:0] in_entry_s;
    logic [31:0]        a_sel_s, b_sel_s;
    logic [1:0]         type_s;
    logic               regwrite_s;
    logic               accept_s, drain_s;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf,
                                            input logic [31:0] ex,
                                            input logic [31:0] wb);
        logic [31:0] res;
        case (sel)
            2'b01:   res = ex;
            2'b10:   res = wb;
            default: res = rf;
        endcase
        return res;
    endfunction

    assign in_ready  = ~state_r[1];
    assign out_valid = state_r[0];
    assign accept_s  = in_valid & ~state_r[1];
    assign drain_s   = state_r[0] & out_ready;

    // Build the incoming entry: forward operands now and turn illegal types into bubbles.
    always_comb begin
        a_sel_s    = fwd_mux(fwd_a_sel, rs1_data, exmem_result, memwb_result);
        b_sel_s    = fwd_mux(fwd_b_sel, rs2_data, exmem_result, memwb_result);
        type_s     = type_in;
        regwrite_s = regwrite_in;
        if (type_in == 2'b11) begin
            type_s     = 2'b00;
            regwrite_s = 1'b0;
        end else begin
            type_s     = type_in;
            regwrite_s = regwrite_in;
        end
        in_entry_s = {a_sel_s, b_sel_s, shamt_in, alusrc_in, type_s, rd_in, regwrite_s};
    end

    // Occupancy and entry movement; vacated slots are zeroed so idle outputs read 0.
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            head_s  = {ENTRY_W{1'b0}};
            skid_s  = {ENTRY_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_s  = in_entry_s;
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        head_s  = in_entry_s;
                        state_s = ST_ONE;
                    end else if (accept_s) begin
                        skid_s  = in_entry_s;
                        state_s = ST_TWO;
                    end else if (drain_s) begin
                        head_s  = {ENTRY_W{1'b0}};
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        head_s  = skid_r;
                        skid_s  = {ENTRY_W{1'b0}};
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    head_s  = {ENTRY_W{1'b0}};
                    skid_s  = {ENTRY_W{1'b0}};
                end
            endcase
        end
    end

    // State and storage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            head_r  <= {ENTRY_W{1'b0}};
            skid_r  <= {ENTRY_W{1'b0}};
        end else begin
            state_r <= state_s;
            head_r  <= head_s;
            skid_r  <= skid_s;
        end
    end

    assign a_out        = head_r[77:46];
    assign b_out        = head_r[45:14];
    assign shamt_out    = head_r[13:9];
    assign alusrc_out   = head_r[8];
    assign type_out     = head_r[7:6];
    assign rd_out       = head_r[5:1];
    assign regwrite_out = head_r[0];

endmodule

// File: tb/tb_id_ex_shift_reg.sv
// Directed self-checking bench for id_ex_shift_reg.
module tb_id_ex_shift_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  shamt_in;
    logic        alusrc_in;
    logic [1:0]  type_in;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] exmem_result, memwb_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_out, b_out;
    logic [4:0]  shamt_out;
    logic        alusrc_out;
    logic [1:0]  type_out;
    logic [4:0]  rd_out;
    logic        regwrite_out;

    int passed;
    int total;

    id_ex_shift_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .shamt_in(shamt_in),
        .alusrc_in(alusrc_in), .type_in(type_in), .rd_in(rd_in),
        .regwrite_in(regwrite_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .exmem_result(exmem_result), .memwb_result(memwb_result), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out),
        .shamt_out(shamt_out), .alusrc_out(alusrc_out), .type_out(type_out),
        .rd_out(rd_out), .regwrite_out(regwrite_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] sh, input logic [1:0] ty,
                          input logic [4:0] rd, input logic rw);
        in_valid    = 1'b1;
        rs1_data    = r1;
        rs2_data    = r2;
        shamt_in    = sh;
        alusrc_in   = 1'b1;
        type_in     = ty;
        rd_in       = rd;
        regwrite_in = rw;
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", in_ready); else passed++;
        total++; if ({a_out, b_out, shamt_out, rd_out, regwrite_out} !== 75'd0)
            $display("FAIL reset_data got a=%h b=%h", a_out, b_out); else passed++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_op(32'h0000_00F0, 32'h0000_1234, 5'd4, 2'b00, 5'd7, 1'b1);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", out_valid); else passed++;
        total++; if (a_out !== 32'h0000_00F0) $display("FAIL single_a got %h exp 000000f0", a_out); else passed++;
        total++; if (b_out !== 32'h0000_1234) $display("FAIL single_b got %h exp 00001234", b_out); else passed++;
        total++; if (shamt_out !== 5'd4) $display("FAIL single_shamt got %0d exp 4", shamt_out); else passed++;
        total++; if (type_out !== 2'b00 || alusrc_out !== 1'b1 || rd_out !== 5'd7 || regwrite_out !== 1'b1)
            $display("FAIL single_ctrl got t=%b s=%b rd=%0d w=%b exp 00 1 7 1", type_out, alusrc_out, rd_out, regwrite_out);
        else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %0b exp 0", out_valid); else passed++;
        total++; if (a_out !== 32'd0) $display("FAIL single_idle_a got %h exp 0", a_out); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_op(32'hAAAA_0001, 32'h0, 5'd1, 2'b01, 5'd1, 1'b1);
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %0b exp 1", in_ready); else passed++;
        set_op(32'hBBBB_0002, 32'h0, 5'd2, 2'b10, 5'd2, 1'b1);
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full got %0b exp 0", in_ready); else passed++;
        set_op(32'hCCCC_0003, 32'h0, 5'd3, 2'b00, 5'd3, 1'b1);
        step();
        total++; if (a_out !== 32'hAAAA_0001 || type_out !== 2'b01)
            $display("FAIL bp_hold_a got %h t=%b exp aaaa0001 01", a_out, type_out); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready got %0b exp 0", in_ready); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (a_out !== 32'hBBBB_0002 || type_out !== 2'b10 || out_valid !== 1'b1)
            $display("FAIL bp_b got %h t=%b v=%b exp bbbb0002 10 1", a_out, type_out, out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready2 got %0b exp 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (a_out !== 32'hCCCC_0003 || rd_out !== 5'd3 || out_valid !== 1'b1)
            $display("FAIL bp_c got %h rd=%0d v=%b exp cccc0003 3 1", a_out, rd_out, out_valid); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_forwarding();
        out_ready = 1'b0;
        set_op(32'h1111_1111, 32'h2222_2222, 5'd9, 2'b01, 5'd9, 1'b1);
        fwd_a_sel    = 2'b01;
        fwd_b_sel    = 2'b10;
        exmem_result = 32'hDEAD_BEEF;
        memwb_result = 32'h0000_0003;
        step();
        in_valid = 1'b0;
        total++; if (a_out !== 32'hDEAD_BEEF) $display("FAIL fwd_a got %h exp deadbeef", a_out); else passed++;
        total++; if (b_out !== 32'h0000_0003) $display("FAIL fwd_b got %h exp 00000003", b_out); else passed++;
        exmem_result = 32'h0BAD_F00D;
        step();
        total++; if (a_out !== 32'hDEAD_BEEF) $display("FAIL fwd_held got %h exp deadbeef", a_out); else passed++;
        out_ready = 1'b1;
        set_op(32'h5555_5555, 32'h6666_6666, 5'd1, 2'b00, 5'd1, 1'b0);
        fwd_a_sel = 2'b11;
        fwd_b_sel = 2'b01;
        step();
        in_valid = 1'b0;
        total++; if (a_out !== 32'h5555_5555 || b_out !== 32'h0BAD_F00D)
            $display("FAIL fwd_sel11 got a=%h b=%h exp 55555555 0badf00d", a_out, b_out); else passed++;
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_op(32'h0000_0042, 32'h0, 5'd5, 2'b11, 5'd12, 1'b1);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL illegal_valid got %0b exp 1", out_valid); else passed++;
        total++; if (type_out !== 2'b00) $display("FAIL illegal_type got %b exp 00", type_out); else passed++;
        total++; if (regwrite_out !== 1'b0) $display("FAIL illegal_rw got %b exp 0", regwrite_out); else passed++;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_op(32'h0000_0A0A, 32'h0, 5'd1, 2'b00, 5'd1, 1'b1);
        step();
        set_op(32'h0000_0B0B, 32'h0, 5'd2, 2'b00, 5'd2, 1'b1);
        step();
        set_op(32'h0000_0D0D, 32'h0, 5'd3, 2'b00, 5'd3, 1'b1);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %0b exp 1", in_ready); else passed++;
        total++; if (a_out !== 32'd0) $display("FAIL flush_a got %h exp 0", a_out); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_nodeliver got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_op(32'h0000_1111, 32'h0000_2222, 5'd1, 2'b00, 5'd1, 1'b1);
        step();
        set_op(32'h0000_3333, 32'h0000_4444, 5'd2, 2'b00, 5'd2, 1'b1);
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b exp 0", out_valid); else passed++;
        total++; if ({a_out, b_out, shamt_out, rd_out, regwrite_out} !== 75'd0)
            $display("FAIL arst_data got a=%h b=%h", a_out, b_out); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL arst_ready got %0b exp 1", in_ready); else passed++;
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        set_op(32'h0000_7777, 32'h0, 5'd7, 2'b10, 5'd7, 1'b1);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || a_out !== 32'h0000_7777)
            $display("FAIL arst_first got v=%b a=%h exp 1 00007777", out_valid, a_out); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL arst_noskid got %0b exp 0", out_valid); else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        rs1_data     = 32'd0;
        rs2_data     = 32'd0;
        shamt_in     = 5'd0;
        alusrc_in    = 1'b0;
        type_in      = 2'b00;
        rd_in        = 5'd0;
        regwrite_in  = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        exmem_result = 32'd0;
        memwb_result = 32'd0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_forwarding();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
